// File: rtl/cmp_unit_pipe.sv
// Two-stage pipelined comparator with val/rdy handshakes on both sides and a
// saturating count of consumed true results.
module cmp_unit_pipe #(
    parameter int NBITS    = 16,
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_val,
    output logic                in_rdy,
    input  logic [NBITS-1:0]    in0,
    input  logic [NBITS-1:0]    in1,
    input  logic [2:0]          op,
    output logic                out_val,
    input  logic                out_rdy,
    output logic                result,
    output logic                out_eq,
    output logic                out_err,
    input  logic                count_clr,
    output logic [CNT_BITS-1:0] true_count
);

    typedef enum logic [2:0] {
        OP_EQ  = 3'b000,
        OP_NE  = 3'b001,
        OP_LT  = 3'b010,
        OP_GE  = 3'b011,
        OP_LTU = 3'b100,
        OP_GEU = 3'b101
    } cmp_op_e;

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic             a_val;
    logic [NBITS-1:0] a_in0;
    logic [NBITS-1:0] a_in1;
    logic [2:0]       a_op;

    logic b_adv;
    logic a_adv;
    logic a_eq;
    logic a_lts;
    logic a_ltu;
    logic a_rel;
    logic a_ill;

    // Stage B moves whenever its slot is empty or being consumed; stage A
    // moves into an empty B even under backpressure, collapsing bubbles.
    assign b_adv  = !out_val || out_rdy;
    assign a_adv  = !a_val || b_adv;
    assign in_rdy = a_adv;

    always_comb begin
        a_eq  = (a_in0 == a_in1);
        a_lts = ($signed(a_in0) < $signed(a_in1));
        a_ltu = (a_in0 < a_in1);
        a_rel = 1'b0;
        a_ill = 1'b0;
        case (a_op)
            OP_EQ:   a_rel = a_eq;
            OP_NE:   a_rel = !a_eq;
            OP_LT:   a_rel = a_lts;
            OP_GE:   a_rel = !a_lts;
            OP_LTU:  a_rel = a_ltu;
            OP_GEU:  a_rel = !a_ltu;
            default: a_ill = 1'b1;
        endcase
    end

    // Operand registers only load on an actual accept so idle inputs never leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_val <= 1'b0;
            a_in0 <= '0;
            a_in1 <= '0;
            a_op  <= '0;
        end else if (a_adv) begin
            a_val <= in_val;
            if (in_val) begin
                a_in0 <= in0;
                a_in1 <= in1;
                a_op  <= op;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val <= 1'b0;
            result  <= 1'b0;
            out_eq  <= 1'b0;
            out_err <= 1'b0;
        end else if (b_adv) begin
            out_val <= a_val;
            if (a_val) begin
                result  <= a_rel;
                out_eq  <= a_eq;
                out_err <= a_ill;
            end
        end
    end

    // Clear takes priority over a coincident true consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            true_count <= '0;
        end else if (count_clr) begin
            true_count <= '0;
        end else if (out_val && out_rdy && result && (true_count != CNT_MAX)) begin
            true_count <= true_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cmp_unit_pipe.sv
// Self-checking bench for cmp_unit_pipe: directed scenarios on a 16-bit and a
// 32-bit/2-bit-counter instance, plus a randomized run against a reference model.
module tb_cmp_unit_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_val, in_rdy, out_val, out_rdy, result, out_eq, out_err, count_clr;
    logic [15:0] in0, in1;
    logic [2:0]  op;
    logic [7:0]  true_count;

    logic        w_in_val, w_in_rdy, w_out_val, w_out_rdy, w_result, w_out_eq, w_out_err, w_count_clr;
    logic [31:0] w_in0, w_in1;
    logic [2:0]  w_op;
    logic [1:0]  w_true_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic r;
        logic eq;
        logic err;
    } exp_t;

    cmp_unit_pipe #(.NBITS(16), .CNT_BITS(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(in_rdy),
        .in0(in0), .in1(in1), .op(op), .out_val(out_val), .out_rdy(out_rdy),
        .result(result), .out_eq(out_eq), .out_err(out_err),
        .count_clr(count_clr), .true_count(true_count)
    );

    cmp_unit_pipe #(.NBITS(32), .CNT_BITS(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_val(w_in_val), .in_rdy(w_in_rdy),
        .in0(w_in0), .in1(w_in1), .op(w_op), .out_val(w_out_val), .out_rdy(w_out_rdy),
        .result(w_result), .out_eq(w_out_eq), .out_err(w_out_err),
        .count_clr(w_count_clr), .true_count(w_true_count)
    );

    // Reference: operands interpreted as integers, signed view by subtracting 2^w.
    function automatic exp_t ref_cmp(input int w, input longint a, input longint b, input logic [2:0] o);
        exp_t   e;
        longint sa, sb;
        sa = (a >= (longint'(1) << (w - 1))) ? a - (longint'(1) << w) : a;
        sb = (b >= (longint'(1) << (w - 1))) ? b - (longint'(1) << w) : b;
        e.eq  = (a == b);
        e.err = 1'b0;
        case (o)
            3'd0:    e.r = (a == b);
            3'd1:    e.r = (a != b);
            3'd2:    e.r = (sa < sb);
            3'd3:    e.r = !(sa < sb);
            3'd4:    e.r = (a < b);
            3'd5:    e.r = !(a < b);
            default: begin e.r = 1'b0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [2:0] o);
        in_val = v;
        in0    = a;
        in1    = b;
        op     = o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0, 16'h0, 3'd0);
        out_rdy = 1'b0; count_clr = 1'b0;
        w_in_val = 1'b0; w_in0 = '0; w_in1 = '0; w_op = '0; w_out_rdy = 1'b0; w_count_clr = 1'b0;
        #3;
        n_cmp++; if (out_val !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_val: got %0b expected 0", out_val); end
        n_cmp++; if (result !== 1'b0) begin n_err++; $display("[TB] FAIL reset_result: got %0b expected 0", result); end
        n_cmp++; if (out_eq !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_eq: got %0b expected 0", out_eq); end
        n_cmp++; if (out_err !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_err: got %0b expected 0", out_err); end
        n_cmp++; if (true_count !== 8'd0) begin n_err++; $display("[TB] FAIL reset_count: got %0d expected 0", true_count); end
        n_cmp++; if (w_out_val !== 1'b0) begin n_err++; $display("[TB] FAIL reset_w_out_val: got %0b expected 0", w_out_val); end
        n_cmp++; if (w_true_count !== 2'd0) begin n_err++; $display("[TB] FAIL reset_w_count: got %0d expected 0", w_true_count); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("[TB] FAIL reset_in_rdy: got %0b expected 1", in_rdy); end
    endtask

    task automatic test_stream();
        logic [15:0] sa [4] = '{16'h1234, 16'h1234, 16'h8000, 16'h8000};
        logic [15:0] sb [4] = '{16'h1234, 16'h1235, 16'h0001, 16'h0001};
        logic [2:0]  so [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
        logic        er [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic        ee [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        out_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 4) applyStimulus(1'b1, sa[k], sb[k], so[k]);
            else       applyStimulus(1'b0, 16'h0, 16'h0, 3'd0);
            #1;
            n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("[TB] FAIL stream_in_rdy[%0d]: got %0b expected 1", k, in_rdy); end
            if (k >= 2) begin
                n_cmp++; if (out_val !== 1'b1) begin n_err++; $display("[TB] FAIL stream_out_val[%0d]: got %0b expected 1", k, out_val); end
                n_cmp++; if (result !== er[k-2]) begin n_err++; $display("[TB] FAIL stream_result[%0d]: got %0b expected %0b", k - 2, result, er[k-2]); end
                n_cmp++; if (out_eq !== ee[k-2]) begin n_err++; $display("[TB] FAIL stream_eq[%0d]: got %0b expected %0b", k - 2, out_eq, ee[k-2]); end
                n_cmp++; if (out_err !== 1'b0) begin n_err++; $display("[TB] FAIL stream_err[%0d]: got %0b expected 0", k - 2, out_err); end
            end else begin
                n_cmp++; if (out_val !== 1'b0) begin n_err++; $display("[TB] FAIL stream_early_val[%0d]: got %0b expected 0", k, out_val); end
            end
        end
    endtask

    task automatic test_width32();
        logic [31:0] wa [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        logic [31:0] wb [3] = '{32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
        logic [2:0]  wo [3] = '{3'd3, 3'd5, 3'd2};
        logic        er [3] = '{1'b0, 1'b1, 1'b0};
        w_out_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            w_in_val = (k < 3);
            w_in0 = (k < 3) ? wa[k] : 32'h0;
            w_in1 = (k < 3) ? wb[k] : 32'h0;
            w_op  = (k < 3) ? wo[k] : 3'd0;
            #1;
            if (k >= 2) begin
                n_cmp++; if (w_out_val !== 1'b1) begin n_err++; $display("[TB] FAIL w32_out_val[%0d]: got %0b expected 1", k - 2, w_out_val); end
                n_cmp++; if (w_result !== er[k-2]) begin n_err++; $display("[TB] FAIL w32_result[%0d]: got %0b expected %0b", k - 2, w_result, er[k-2]); end
                n_cmp++; if (w_out_eq !== 1'b0) begin n_err++; $display("[TB] FAIL w32_eq[%0d]: got %0b expected 0", k - 2, w_out_eq); end
            end
        end
        @(negedge clk);
        w_in_val = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [15:0] ta [3] = '{16'h0005, 16'h0003, 16'hFFFF};
        logic [15:0] tb [3] = '{16'h0005, 16'h0009, 16'h0001};
        logic [2:0]  to [3] = '{3'd0, 3'd4, 3'd2};
        exp_t        ex [3];
        int          acc = 0;
        int          got = 0;
        for (int i = 0; i < 3; i++) ex[i] = ref_cmp(16, longint'(ta[i]), longint'(tb[i]), to[i]);
        out_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (acc < 3) applyStimulus(1'b1, ta[acc], tb[acc], to[acc]);
            else         applyStimulus(1'b0, 16'h0, 16'h0, 3'd0);
            #1;
            if (c >= 2) begin
                n_cmp++; if (out_val !== 1'b1) begin n_err++; $display("[TB] FAIL bp_hold_val[%0d]: got %0b expected 1", c, out_val); end
                n_cmp++; if ({result, out_eq, out_err} !== ex[0]) begin n_err++; $display("[TB] FAIL bp_hold_data[%0d]: got %b expected %b", c, {result, out_eq, out_err}, ex[0]); end
            end
            if (in_val && in_rdy) acc++;
        end
        n_cmp++; if (acc !== 2) begin n_err++; $display("[TB] FAIL bp_accepts: got %0d expected 2", acc); end
        n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("[TB] FAIL bp_in_rdy: got %0b expected 0", in_rdy); end
        for (int c = 0; c < 20 && got < 3; c++) begin
            @(negedge clk);
            out_rdy = 1'b1;
            if (acc < 3) applyStimulus(1'b1, ta[acc], tb[acc], to[acc]);
            else         applyStimulus(1'b0, 16'h0, 16'h0, 3'd0);
            #1;
            if (out_val) begin
                n_cmp++; if ({result, out_eq, out_err} !== ex[got]) begin n_err++; $display("[TB] FAIL bp_order[%0d]: got %b expected %b", got, {result, out_eq, out_err}, ex[got]); end
                got++;
            end
            if (in_val && in_rdy) acc++;
        end
        n_cmp++; if (got !== 3) begin n_err++; $display("[TB] FAIL bp_delivered: got %0d expected 3", got); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            applyStimulus(1'b0, 16'h0, 16'h0, 3'd0);
            #1;
            n_cmp++; if (out_val !== 1'b0) begin n_err++; $display("[TB] FAIL bp_duplicate[%0d]: got %0b expected 0", c, out_val); end
        end
    endtask

    task automatic test_illegal();
        logic [7:0] cnt0 = '0;
        out_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0)      applyStimulus(1'b1, 16'h00FF, 16'h00FF, 3'b110);
            else if (k == 1) applyStimulus(1'b1, 16'h0001, 16'h0002, 3'b111);
            else             applyStimulus(1'b0, 16'h0, 16'h0, 3'd0);
            #1;
            if (k == 0) cnt0 = true_count;
            if (k == 2 || k == 3) begin
                n_cmp++; if (out_val !== 1'b1) begin n_err++; $display("[TB] FAIL ill_val[%0d]: got %0b expected 1", k, out_val); end
                n_cmp++; if (result !== 1'b0) begin n_err++; $display("[TB] FAIL ill_result[%0d]: got %0b expected 0", k, result); end
                n_cmp++; if (out_err !== 1'b1) begin n_err++; $display("[TB] FAIL ill_err[%0d]: got %0b expected 1", k, out_err); end
                n_cmp++; if (out_eq !== (k == 2)) begin n_err++; $display("[TB] FAIL ill_eq[%0d]: got %0b expected %0b", k, out_eq, (k == 2)); end
            end
        end
        n_cmp++; if (true_count !== cnt0) begin n_err++; $display("[TB] FAIL ill_count: got %0d expected %0d", true_count, cnt0); end
    endtask

    task automatic test_saturate();
        int          c = 0;
        int          expc;
        logic        seen = 1'b0;
        logic [31:0] v;
        w_out_rdy = 1'b1;
        @(negedge clk);
        w_count_clr = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            w_count_clr = 1'b0;
            v = $urandom;
            w_in_val = (k < 5); w_in0 = v; w_in1 = v; w_op = 3'd0;
            #1;
            expc = (c > 3) ? 3 : c;
            n_cmp++; if (w_true_count !== 2'(expc)) begin n_err++; $display("[TB] FAIL sat_count[%0d]: got %0d expected %0d", k, w_true_count, expc); end
            if (w_out_val && w_out_rdy) c++;
        end
        n_cmp++; if (c !== 5) begin n_err++; $display("[TB] FAIL sat_consumed: got %0d expected 5", c); end
        @(negedge clk);
        w_in_val = 1'b1; w_in0 = 32'h55; w_in1 = 32'h55; w_op = 3'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            w_in_val = 1'b0;
            #1;
            if (w_out_val) begin
                seen = 1'b1;
                w_count_clr = 1'b1;
                break;
            end
        end
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("[TB] FAIL clr_timeout: got %0b expected 1", seen); end
        @(negedge clk);
        w_count_clr = 1'b0;
        #1;
        n_cmp++; if (w_true_count !== 2'd0) begin n_err++; $display("[TB] FAIL clr_wins: got %0d expected 0", w_true_count); end
    endtask

    task automatic test_reset_midflight();
        out_rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            applyStimulus(1'b1, 16'(k + 7), 16'(k + 7), 3'd0);
        end
        @(negedge clk);
        applyStimulus(1'b0, 16'h0, 16'h0, 3'd0);
        #1;
        n_cmp++; if (out_val !== 1'b1) begin n_err++; $display("[TB] FAIL mid_inflight: got %0b expected 1", out_val); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_val !== 1'b0) begin n_err++; $display("[TB] FAIL mid_async_val: got %0b expected 0", out_val); end
        n_cmp++; if (result !== 1'b0) begin n_err++; $display("[TB] FAIL mid_async_result: got %0b expected 0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        out_rdy = 1'b1;
        #1;
        n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("[TB] FAIL mid_in_rdy: got %0b expected 1", in_rdy); end
        n_cmp++; if (true_count !== 8'd0) begin n_err++; $display("[TB] FAIL mid_count: got %0d expected 0", true_count); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            n_cmp++; if (out_val !== 1'b0) begin n_err++; $display("[TB] FAIL mid_stale[%0d]: got %0b expected 0", k, out_val); end
        end
    endtask

    // Scoreboard run: queue holds expected outcomes of accepted, unconsumed items.
    task automatic test_random();
        exp_t       q[$];
        exp_t       e;
        int         cnt_m = 0;
        logic       cons_true;
        logic [15:0] a;
        for (int cyc = 0; cyc < 410; cyc++) begin
            @(negedge clk);
            if (cyc < 400) begin
                a = 16'($urandom);
                applyStimulus(($urandom % 4) != 0, a, (($urandom % 3) == 0) ? a : 16'($urandom), 3'($urandom % 8));
                out_rdy   = ($urandom % 4) != 0;
                count_clr = ($urandom % 40) == 0;
            end else begin
                applyStimulus(1'b0, 16'h0, 16'h0, 3'd0);
                out_rdy   = 1'b1;
                count_clr = 1'b0;
            end
            #1;
            n_cmp++; if (in_rdy !== ((q.size() < 2) || out_rdy)) begin n_err++; $display("[TB] FAIL rnd_in_rdy[%0d]: got %0b expected %0b", cyc, in_rdy, ((q.size() < 2) || out_rdy)); end
            n_cmp++; if (true_count !== 8'(cnt_m)) begin n_err++; $display("[TB] FAIL rnd_count[%0d]: got %0d expected %0d", cyc, true_count, cnt_m); end
            cons_true = 1'b0;
            if (out_val) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++; $display("[TB] FAIL rnd_spurious[%0d]: got out_val 1 expected 0", cyc);
                end else begin
                    if ({result, out_eq, out_err} !== q[0]) begin n_err++; $display("[TB] FAIL rnd_data[%0d]: got %b expected %b", cyc, {result, out_eq, out_err}, q[0]); end
                    if (out_rdy) begin
                        e = q.pop_front();
                        cons_true = e.r;
                    end
                end
            end
            if (count_clr) cnt_m = 0;
            else if (cons_true && cnt_m < 255) cnt_m++;
            if (in_val && in_rdy) q.push_back(ref_cmp(16, longint'(in0), longint'(in1), op));
        end
        n_cmp++; if (q.size() !== 0) begin n_err++; $display("[TB] FAIL rnd_drain: got %0d left expected 0", q.size()); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_width32();
        test_backpressure();
        test_illegal();
        test_saturate();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
